// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiply/divide that borrows an external ALU one op per cycle.
// Define MULDIV_DIV_EN to build the restoring divider; without it, divide requests complete with zero results.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  input  logic [31:0] alu_res
);

`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DONE = 3'd4
  } state_t;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [31:0] mul_sum;
  logic        mul_carry;
`ifdef MULDIV_DIV_EN
  logic [31:0] t_q, t_d;
  logic        geq_q, geq_d;
  logic [32:0] div_t;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    alu_op    = ALU_ADD;
    alu_rs    = 32'd0;
    alu_rt    = 32'd0;
    mul_sum   = hi_q;
    mul_carry = 1'b0;
`ifdef MULDIV_DIV_EN
    t_d       = t_q;
    geq_d     = geq_q;
    div_t     = {hi_q, lo_q[31]};
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          b_d   = b;
          cnt_d = 6'd0;
          if (!op) begin
            hi_d    = 32'd0;
            lo_d    = a;
            state_d = S_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
              hi_d    = a;
              lo_d    = 32'hFFFF_FFFF;
              state_d = S_DONE;
            end else begin
              hi_d    = 32'd0;
              lo_d    = a;
              state_d = S_DIV_CMP;
            end
`else
            hi_d    = 32'd0;
            lo_d    = 32'd0;
            state_d = S_DONE;
`endif
          end
        end
      end
      S_MUL: begin
        alu_op = ALU_ADD;
        alu_rs = hi_q;
        alu_rt = b_q;
        // The adder carry-out is recovered from unsigned wrap of the sum.
        if (lo_q[0]) begin
          mul_sum   = alu_res;
          mul_carry = (alu_res < hi_q);
        end
        hi_d  = {mul_carry, mul_sum[31:1]};
        lo_d  = {mul_sum[0], lo_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
`ifdef MULDIV_DIV_EN
      S_DIV_CMP: begin
        alu_op  = ALU_SLT;
        alu_rs  = div_t[31:0];
        alu_rt  = b_q;
        t_d     = div_t[31:0];
        geq_d   = div_t[32] | (alu_res == 32'd0);
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        alu_op  = ALU_SUB;
        alu_rs  = t_q;
        alu_rt  = b_q;
        hi_d    = geq_q ? alu_res : t_q;
        lo_d    = {lo_q[30:0], geq_q};
        cnt_d   = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? S_DONE : S_DIV_CMP;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      b_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
      t_q     <= 32'd0;
      geq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
`ifdef MULDIV_DIV_EN
      t_q     <= t_d;
      geq_q   <= geq_d;
`endif
    end
  end

`ifdef MULDIV_DIV_EN
  assign busy = (state_q == S_MUL) || (state_q == S_DIV_CMP) || (state_q == S_DIV_SUB);
`else
  assign busy = (state_q == S_MUL);
`endif
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [2:0]  alu_op;
  logic [31:0] alu_rs, alu_rt, alu_res;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      3'b000: alu_res = alu_rs & alu_rt;
      3'b001: alu_res = alu_rs | alu_rt;
      3'b010: alu_res = alu_rs + alu_rt;
      3'b011: alu_res = {alu_rt[15:0], 16'h0000};
      3'b110: alu_res = alu_rs - alu_rt;
      3'b111: alu_res = (alu_rs < alu_rt) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request; if now_edge is set the caller is already at a negedge.
  task automatic launch(input logic o, input logic [31:0] av, input logic [31:0] bv, input bit now_edge);
    if (!now_edge) @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns at the negedge where done is seen.
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt,
                           output logic [2:0] op1, output logic [2:0] op2);
    lat = 1; busy_cnt = 0; op1 = alu_op; op2 = 3'bxxx;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == poke_at) begin
        start = 1'b1; op = 1'b1; a = 32'd7; b = 32'd0;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 2) op2 = alu_op;
    end
  endtask

  int lat, bc, dones;
  logic [2:0] o1, o2;

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_alu", {alu_op, alu_rs, alu_rt}, {3'b010, 64'd0});
    reset_n = 1'b1;

    launch(1'b0, 32'hB, 32'h7, 1'b0);
    check("mul_alu_c1", {alu_op, alu_rs, alu_rt}, {3'b010, 32'd0, 32'd7});
    wait_done(0, lat, bc, o1, o2);
    check("mul_lat", lat, 33);
    check("mul_busy_cycles", bc, 32);
    check("mul_busy_at_done", busy, 0);
    check("mul_res", {hi, lo}, 64'h0000_0000_0000_004D);
    check("done_alu_idle", {alu_op, alu_rs, alu_rt}, {3'b010, 64'd0});
    @(negedge clk);
    check("done_one_cycle", {done, busy}, 2'b00);
    check("mul_hold", {hi, lo}, 64'h4D);

    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("mulmax_lat", lat, 33);
    check("mulmax_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    launch(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("mul_x2_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    launch(1'b0, 32'd0, 32'd5, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("mul_zero_res", {hi, lo}, 64'd0);

    launch(1'b0, 32'd3, 32'd5, 1'b0);
    wait_done(10, lat, bc, o1, o2);
    check("ignore_lat", lat, 33);
    check("ignore_res", {hi, lo}, 64'd15);

    launch(1'b0, 32'd6, 32'd7, 1'b1);
    check("b2b_busy", {busy, done}, 2'b10);
    wait_done(0, lat, bc, o1, o2);
    check("b2b_lat", lat, 33);
    check("b2b_res", {hi, lo}, 64'd42);

`ifdef MULDIV_DIV_EN
    launch(1'b1, 32'd100, 32'd7, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("div_lat", lat, 65);
    check("div_busy_cycles", bc, 64);
    check("div_alu_ops", {o1, o2}, {3'b111, 3'b110});
    check("div_res", {hi, lo}, {32'd2, 32'd14});

    launch(1'b1, 32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("div_big_res", {hi, lo}, {32'hF, 32'h0FFF_FFFF});

    launch(1'b1, 32'h1234, 32'd0, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("div0_lat", lat, 1);
    check("div0_res", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
`else
    launch(1'b1, 32'd100, 32'd7, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("nodiv_lat", lat, 1);
    check("nodiv_res", {hi, lo}, 64'd0);

    launch(1'b1, 32'h1234, 32'd0, 1'b0);
    wait_done(0, lat, bc, o1, o2);
    check("nodiv0_res", {hi, lo}, 64'd0);
`endif

`ifdef MULDIV_DIV_EN
    launch(1'b1, 32'd100, 32'd7, 1'b0);
`else
    launch(1'b0, 32'd100, 32'd7, 1'b0);
`endif
    repeat (4) @(negedge clk);
    reset_n = 1'b0; start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    check("midrst_state", {busy, done}, 2'b00);
    check("midrst_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midrst_no_done", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports clk and reset_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 start  in  1  operation request; sampled only when busy=0.
REQ-005 op  in  1  0=unsigned multiply, 1=unsigned divide.
REQ-006 a, b  in  32 each  multiplicand/dividend (a), multiplier/divisor (b); captured at accept.
REQ-007 busy  out  1  high while iterating.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 hi, lo  out  32 each  result: multiply {hi,lo}=a*b; divide lo=quotient, hi=remainder.
REQ-010 alu_op  out  3  opcode to shared ALU (000 and, 001 or, 010 add, 011 lui, 110 sub, 111 slt).
REQ-011 alu_rs, alu_rt  out  32 each  ALU operands.
REQ-012 alu_res  in  32  combinational ALU result, consumed in the same cycle.

Function
REQ-013 States SHALL be IDLE, MUL, DIV_CMP, DIV_SUB, DONE; 6-bit iteration counter.
REQ-014 Accept: start=1 and busy=0 (IDLE or DONE) at a clk edge captures a, b, op and clears hi/lo working state.
REQ-015 start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-016 Multiply init: hi=0, lo=a, mcand=b, next state MUL, counter=0.
REQ-017 MUL cycle: alu_op=010, alu_rs=hi, alu_rt=mcand; if lo[0]=1 sum=alu_res, carry=(alu_res<hi unsigned), else sum=hi, carry=0; then {hi,lo} <= {carry,sum,lo} >> 1.
REQ-018 MUL SHALL run exactly 32 cycles, then DONE.
REQ-019 Divide init (b!=0): hi(rem)=0, lo(quot)=a, next state DIV_CMP, counter=0.
REQ-020 DIV_CMP: T={hi,lo[31]} (33 bits); alu_op=111, alu_rs=T[31:0], alu_rt=b; geq=T[32] | (alu_res==0); register T[31:0] and geq; go DIV_SUB.
REQ-021 DIV_SUB: alu_op=110, alu_rs=T[31:0], alu_rt=b; hi<=geq?alu_res:T[31:0]; lo<={lo[30:0],geq}; after 32nd DIV_SUB go DONE, else DIV_CMP.
REQ-022 Divide by zero: accept goes directly to DONE; hi=a, lo=32'hFFFFFFFF.
REQ-023 Latency from accepting edge to done=1: multiply 33 cycles, divide 65 cycles, divide-by-zero 1 cycle.
REQ-024 busy=1 exactly in MUL, DIV_CMP, DIV_SUB; done=1 exactly in DONE (one cycle), then IDLE unless a new start is accepted in DONE.
REQ-025 hi/lo SHALL hold final results from the DONE cycle until the next accept.
REQ-026 In IDLE and DONE, alu_op=010, alu_rs=0, alu_rt=0.
REQ-027 All arithmetic SHALL be unsigned modulo 2^32; the carry/compare logic SHALL be the only width extension.

Reset
REQ-028 reset_n=0 at a clk edge SHALL force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, alu outputs per REQ-026, regardless of state.
REQ-029 Reset mid-operation SHALL abandon the operation with no done pulse; start during reset is ignored.

Configuration
REQ-030 With macro MULDIV_DIV_EN defined, divide SHALL behave per REQ-019..REQ-022.
REQ-031 Without MULDIV_DIV_EN, DIV_CMP/DIV_SUB SHALL not exist; op=1 accept goes directly to DONE with hi=0, lo=0; multiply unchanged.

Verification
REQ-032 op=0, a=0xB, b=0x7 -> done at cycle 33, hi=0, lo=0x4D; busy high cycles 1-32.
REQ-033 op=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at cycle 33.
REQ-034 op=1, a=100, b=7 (MULDIV_DIV_EN) -> done at cycle 65, lo=14, hi=2; alu_op alternates 111/110.
REQ-035 op=1, b=0 -> done at cycle 1, hi=a, lo=0xFFFFFFFF; without macro, op=1 a=100 b=7 -> done cycle 1, hi=lo=0.
REQ-036 start pulsed at cycle 10 of a multiply -> ignored, original result correct; start in DONE cycle -> back-to-back op accepted, busy next cycle.
REQ-037 reset_n=0 at cycle 5 of divide -> next cycle IDLE, busy=0, hi=lo=0, no done pulse.
